// File: rtl/aes_pkg.sv
// Shared AES datapath constants and types used by the round stages.
package aes_pkg;

  localparam int unsigned AES_BLOCK_W = 128;
  localparam int unsigned AES_NR_128  = 10;
  localparam int unsigned AES_NR_192  = 12;
  localparam int unsigned AES_NR_256  = 14;

  // Wide enough for the largest key schedule (AES-256).
  localparam int unsigned AES_IDX_W = $clog2(AES_NR_256 + 1);

  typedef logic [AES_IDX_W-1:0] aes_round_idx_t;

endpackage

// File: rtl/aes_skid_buf.sv
// Two-entry valid/ready skid buffer with a registered in_ready; payload is opaque.
module aes_skid_buf #(
  parameter int unsigned WIDTH = 132
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic             main_valid_q, main_valid_d;
  logic             skid_valid_q, skid_valid_d;
  logic             ready_q, ready_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             accept;
  logic             main_free;

  assign accept    = in_valid && ready_q;
  assign main_free = !main_valid_q || out_ready;

  always_comb begin
    main_valid_d = main_valid_q;
    main_d       = main_q;
    skid_valid_d = skid_valid_q;
    skid_d       = skid_q;
    if (main_free) begin
      // A full skid implies in_ready was low, so no new beat competes with it.
      if (skid_valid_q) begin
        main_valid_d = 1'b1;
        main_d       = skid_q;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        main_valid_d = 1'b1;
        main_d       = in_data;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_d       = in_data;
    end
    ready_d = !skid_valid_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      ready_q      <= 1'b1;
      main_q       <= '0;
      skid_q       <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      ready_q      <= ready_d;
      main_q       <= main_d;
      skid_q       <= skid_d;
    end
  end

  assign in_ready  = ready_q;
  assign out_valid = main_valid_q;
  assign out_data  = main_q;

endmodule

// File: rtl/add_round_key_stage.sv
// AddRoundKey stage: holds the round-key schedule and XORs each beat with its selected key.
module add_round_key_stage
  import aes_pkg::*;
#(
  parameter int unsigned DATA_W = AES_BLOCK_W,
  parameter int unsigned NR     = AES_NR_128,
  parameter int unsigned IDX_W  = $clog2(NR + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              key_wr_en,
  input  logic [IDX_W-1:0]  key_wr_idx,
  input  logic [DATA_W-1:0] key_wr_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [IDX_W-1:0]  in_round,
  input  logic              in_inverse,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [IDX_W-1:0]  out_round,
  output logic              err_idx
);

  localparam int unsigned      NKEYS  = NR + 1;
  localparam logic [IDX_W-1:0] NR_IDX = IDX_W'(NR);

  logic [DATA_W-1:0]       key_q [NKEYS];
  logic [DATA_W-1:0]       key_sel;
  logic [IDX_W-1:0]        eff_idx;
  logic                    round_oob;
  logic                    wr_oob;
  logic                    accept;
  logic                    err_q, err_d;
  logic [IDX_W+DATA_W-1:0] buf_in;
  logic [IDX_W+DATA_W-1:0] buf_out;

  assign accept    = in_valid && in_ready;
  assign round_oob = in_round > NR_IDX;
  assign wr_oob    = key_wr_idx > NR_IDX;
  assign eff_idx   = in_inverse ? (NR_IDX - in_round) : in_round;

  // Reads the pre-edge key file, so a same-cycle write is seen only by later beats.
  always_comb begin
    key_sel = '0;
    if (!round_oob) begin
      for (int i = 0; i < NKEYS; i++) begin
        if (eff_idx == IDX_W'(i)) begin
          key_sel = key_q[i];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NKEYS; i++) begin
        key_q[i] <= '0;
      end
    end else if (key_wr_en && !wr_oob) begin
      for (int i = 0; i < NKEYS; i++) begin
        if (key_wr_idx == IDX_W'(i)) begin
          key_q[i] <= key_wr_data;
        end
      end
    end
  end

  always_comb begin
    err_d = err_q;
    if ((key_wr_en && wr_oob) || (accept && round_oob)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_idx = err_q;
  assign buf_in  = {in_round, in_data ^ key_sel};

  aes_skid_buf #(
    .WIDTH(IDX_W + DATA_W)
  ) u_skid_buf (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (buf_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (buf_out)
  );

  assign out_round = buf_out[IDX_W+DATA_W-1:DATA_W];
  assign out_data  = buf_out[DATA_W-1:0];

endmodule

// File: tb/tb_add_round_key_stage.sv
// Randomised and directed checks of add_round_key_stage against a queue-based key/XOR model.
module tb_add_round_key_stage;

  localparam int NR = 10;

  typedef struct packed {
    logic [3:0]   round;
    logic [127:0] data;
  } beat_t;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         key_wr_en = 1'b0;
  logic [3:0]   key_wr_idx = '0;
  logic [127:0] key_wr_data = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_data = '0;
  logic [3:0]   in_round = '0;
  logic         in_inverse = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [127:0] out_data;
  logic [3:0]   out_round;
  logic         err_idx;

  int vectors = 0;
  int miscompares = 0;

  logic [127:0] mkeys [NR+1];
  bit           merr = 1'b0;
  beat_t        exp_q [$];

  add_round_key_stage #(
    .DATA_W(128),
    .NR    (NR),
    .IDX_W (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .key_wr_en  (key_wr_en),
    .key_wr_idx (key_wr_idx),
    .key_wr_data(key_wr_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_round   (in_round),
    .in_inverse (in_inverse),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_round  (out_round),
    .err_idx    (err_idx)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1);
  end

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One clock: sample handshakes mid-cycle, advance the model, land #1 after the edge.
  task automatic tick(output bit acc, output bit fire, output beat_t obs);
    beat_t e;
    @(negedge clk);
    acc       = in_valid && in_ready;
    fire      = out_valid && out_ready;
    obs.data  = out_data;
    obs.round = out_round;
    if (acc) begin
      e.round = in_round;
      if (int'(in_round) > NR) begin
        e.data = in_data;
        merr   = 1'b1;
      end else begin
        e.data = in_data ^ mkeys[in_inverse ? NR - int'(in_round) : int'(in_round)];
      end
      exp_q.push_back(e);
    end
    if (key_wr_en) begin
      if (int'(key_wr_idx) <= NR) mkeys[key_wr_idx] = key_wr_data;
      else merr = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid  = 1'b0;
    key_wr_en = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic test_reset();
    for (int i = 0; i <= NR; i++) mkeys[i] = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== '0 || out_round !== '0 ||
        err_idx !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_values: got rdy=%b vld=%b data=%h round=%0d err=%b, want 1 0 0 0 0",
               in_ready, out_valid, out_data, out_round, err_idx);
    end
  endtask

  task automatic load_keys();
    bit acc, fire;
    beat_t obs;
    logic [127:0] ones01;
    ones01 = {16{8'h01}};
    for (int i = 0; i <= NR; i++) begin
      key_wr_en   = 1'b1;
      key_wr_idx  = 4'(i);
      key_wr_data = 128'(i) * ones01;
      tick(acc, fire, obs);
    end
    key_wr_en = 1'b0;
  endtask

  task automatic test_key_select(input bit inv, input logic [127:0] want);
    bit acc, fire;
    beat_t obs;
    out_ready  = 1'b1;
    in_valid   = 1'b1;
    in_data    = '0;
    in_round   = 4'd3;
    in_inverse = inv;
    tick(acc, fire, obs);
    in_valid = 1'b0;
    vectors++;
    if (out_valid !== 1'b1 || out_data !== want || out_round !== 4'd3) begin
      miscompares++;
      $display("FAIL key_select inv=%0b: got vld=%b data=%h round=%0d, want 1 %h 3",
               inv, out_valid, out_data, out_round, want);
    end
    tick(acc, fire, obs);
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL key_select_once inv=%0b: got out_valid=%b, want 0", inv, out_valid);
    end
    exp_q.delete();
  endtask

  task automatic test_back_to_back();
    beat_t src [8];
    bit    sinv [8];
    bit    acc, fire;
    beat_t obs, e;
    int    sent = 0;
    int    got = 0;
    for (int i = 0; i < 8; i++) begin
      src[i].data  = rnd128();
      src[i].round = 4'($urandom_range(0, NR));
      sinv[i]      = 1'($urandom_range(0, 1));
    end
    for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
      if (cyc >= 2 && cyc <= 5) begin
        vectors++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || sent != 2 ||
            out_data !== exp_q[0].data) begin
          miscompares++;
          $display("FAIL stall_hold cyc=%0d: got rdy=%b vld=%b sent=%0d data=%h, want 0 1 2 %h",
                   cyc, in_ready, out_valid, sent, out_data, exp_q[0].data);
        end
      end
      in_valid = (sent < 8);
      if (sent < 8) begin
        in_data    = src[sent].data;
        in_round   = src[sent].round;
        in_inverse = sinv[sent];
      end
      out_ready = (cyc == 0 || cyc >= 6);
      tick(acc, fire, obs);
      if (acc) sent++;
      if (fire) begin
        vectors++;
        got++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL b2b_extra: got %h/%0d, want no beat", obs.data, obs.round);
        end else begin
          e = exp_q.pop_front();
          if (obs !== e) begin
            miscompares++;
            $display("FAIL b2b_beat %0d: got %h/%0d, want %h/%0d",
                     got, obs.data, obs.round, e.data, e.round);
          end
        end
      end
    end
    idle_inputs();
    tick(acc, fire, obs);
    vectors++;
    if (got != 8 || fire || out_valid !== 1'b0 || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL b2b_count: got %0d beats (trailing vld=%b), want 8 then idle",
               got, out_valid);
    end
    exp_q.delete();
  endtask

  task automatic test_collision();
    bit acc, fire;
    beat_t obs;
    logic [127:0] d1, d2;
    d1 = rnd128();
    d2 = rnd128();
    out_ready   = 1'b1;
    in_valid    = 1'b1;
    in_inverse  = 1'b0;
    in_round    = 4'd5;
    in_data     = d1;
    key_wr_en   = 1'b1;
    key_wr_idx  = 4'd5;
    key_wr_data = '1;
    tick(acc, fire, obs);
    key_wr_en = 1'b0;
    vectors++;
    if (out_data !== (d1 ^ {16{8'h05}})) begin
      miscompares++;
      $display("FAIL collision_old_key: got %h, want %h", out_data, d1 ^ {16{8'h05}});
    end
    in_data = d2;
    tick(acc, fire, obs);
    in_valid = 1'b0;
    vectors++;
    if (out_data !== ~d2) begin
      miscompares++;
      $display("FAIL collision_new_key: got %h, want %h", out_data, ~d2);
    end
    tick(acc, fire, obs);
    exp_q.delete();
  endtask

  task automatic test_err_idx();
    bit acc, fire;
    beat_t obs, e;
    logic [127:0] d;
    int got = 0;
    int sent = 0;
    d = rnd128();
    vectors++;
    if (err_idx !== 1'b0) begin
      miscompares++;
      $display("FAIL err_initial: got %b, want 0", err_idx);
    end
    out_ready  = 1'b1;
    in_valid   = 1'b1;
    in_round   = 4'd11;
    in_inverse = 1'b0;
    in_data    = d;
    tick(acc, fire, obs);
    in_valid = 1'b0;
    vectors++;
    if (out_data !== d || out_round !== 4'd11 || err_idx !== 1'b1) begin
      miscompares++;
      $display("FAIL err_round_oob: got %h/%0d err=%b, want %h/11 err=1",
               out_data, out_round, err_idx, d);
    end
    key_wr_en   = 1'b1;
    key_wr_idx  = 4'd12;
    key_wr_data = '1;
    tick(acc, fire, obs);
    key_wr_en = 1'b0;
    exp_q.delete();
    // Read back every entry to confirm the rejected write aliased nowhere.
    for (int cyc = 0; cyc < 40 && got < NR + 1; cyc++) begin
      in_valid   = (sent <= NR);
      in_round   = 4'(sent);
      in_inverse = 1'b0;
      in_data    = '0;
      tick(acc, fire, obs);
      if (acc) sent++;
      if (fire) begin
        vectors++;
        got++;
        e = exp_q.pop_front();
        if (obs !== e) begin
          miscompares++;
          $display("FAIL err_key_intact round %0d: got %h, want %h", obs.round, obs.data, e.data);
        end
      end
    end
    idle_inputs();
    vectors++;
    if (got != NR + 1 || err_idx !== 1'b1) begin
      miscompares++;
      $display("FAIL err_sticky: got %0d beats err=%b, want %0d beats err=1", got, err_idx, NR + 1);
    end
    exp_q.delete();
  endtask

  task automatic test_random();
    bit acc, fire;
    beat_t obs, e;
    for (int cyc = 0; cyc < 600; cyc++) begin
      in_valid    = ($urandom_range(0, 3) != 0) && (cyc < 500);
      in_data     = rnd128();
      in_round    = 4'($urandom_range(0, 11));
      in_inverse  = 1'($urandom_range(0, 1));
      out_ready   = ($urandom_range(0, 2) != 0) || (cyc >= 500);
      key_wr_en   = ($urandom_range(0, 7) == 0) && (cyc < 500);
      key_wr_idx  = 4'($urandom_range(0, 12));
      key_wr_data = rnd128();
      tick(acc, fire, obs);
      if (fire) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL rand_extra: got %h/%0d, want no beat", obs.data, obs.round);
        end else begin
          e = exp_q.pop_front();
          if (obs !== e) begin
            miscompares++;
            $display("FAIL rand_beat cyc %0d: got %h/%0d, want %h/%0d",
                     cyc, obs.data, obs.round, e.data, e.round);
          end
        end
      end
    end
    idle_inputs();
    vectors++;
    if (exp_q.size() != 0 || out_valid !== 1'b0 || err_idx !== merr) begin
      miscompares++;
      $display("FAIL rand_drain: got %0d pending vld=%b err=%b, want 0 pending vld=0 err=%b",
               exp_q.size(), out_valid, err_idx, merr);
    end
    exp_q.delete();
  endtask

  task automatic test_reset_midop();
    bit acc, fire;
    beat_t obs, e;
    int sent = 0;
    int got = 0;
    out_ready  = 1'b0;
    in_valid   = 1'b1;
    in_round   = 4'd1;
    in_inverse = 1'b0;
    in_data    = rnd128();
    tick(acc, fire, obs);
    in_data = rnd128();
    tick(acc, fire, obs);
    in_valid = 1'b0;
    vectors++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL midop_full: got rdy=%b vld=%b, want 0 1", in_ready, out_valid);
    end
    #1 reset = 1'b0;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== '0 || out_round !== '0 ||
        err_idx !== 1'b0) begin
      miscompares++;
      $display("FAIL midop_async: got vld=%b rdy=%b data=%h round=%0d err=%b, want 0 1 0 0 0",
               out_valid, in_ready, out_data, out_round, err_idx);
    end
    for (int i = 0; i <= NR; i++) mkeys[i] = '0;
    merr = 1'b0;
    exp_q.delete();
    @(posedge clk);
    #1 reset = 1'b1;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 40 && got < NR + 1; cyc++) begin
      in_valid   = (sent <= NR);
      in_round   = 4'(sent);
      in_inverse = 1'($urandom_range(0, 1));
      in_data    = rnd128();
      tick(acc, fire, obs);
      if (acc) sent++;
      if (fire) begin
        vectors++;
        got++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL midop_stale: got %h/%0d, want no beat", obs.data, obs.round);
        end else begin
          e = exp_q.pop_front();
          if (obs !== e) begin
            miscompares++;
            $display("FAIL midop_key_zero: got %h/%0d, want %h/%0d",
                     obs.data, obs.round, e.data, e.round);
          end
        end
      end
    end
    idle_inputs();
    vectors++;
    if (got != NR + 1 || err_idx !== 1'b0) begin
      miscompares++;
      $display("FAIL midop_after: got %0d beats err=%b, want %0d beats err=0",
               got, err_idx, NR + 1);
    end
  endtask

  initial begin
    test_reset();
    load_keys();
    test_key_select(1'b0, {16{8'h03}});
    test_key_select(1'b1, {16{8'h07}});
    test_back_to_back();
    test_collision();
    test_err_idx();
    test_random();
    test_reset_midop();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
